// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX hazard inputs, pipeline enables/flushes, PC select, perf counters.
// Latency: pure wiring, no storage.
// Backpressure: none; every signal is valid every cycle.
// Ports: master = datapath side (drives decode/EX status, consumes controls),
//        slave  = hazard_ctrl (consumes status, drives controls and counters).
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  // status from the pipeline
  logic             irq_req;
  logic             pc_kernel;
  logic [5:0]       id_opcode;
  logic [5:0]       id_funct;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             ex_memread;
  logic [4:0]       ex_rt;
  logic             ex_branch;
  logic             ex_branch_taken;
  logic             cnt_clr;
  // controls back to the pipeline
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             irq_take;
  logic [2:0]       pc_src;
  logic [31:0]      irq_vec;     // PC mux input selected by pc_src=4
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output irq_req, pc_kernel, id_opcode, id_funct, id_rs, id_rt,
           ex_memread, ex_rt, ex_branch, ex_branch_taken, cnt_clr,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, irq_take,
           pc_src, irq_vec, stall_cnt, flush_cnt
  );

  modport slave (
    input  irq_req, pc_kernel, id_opcode, id_funct, id_rs, id_rt,
           ex_memread, ex_rt, ex_branch, ex_branch_taken, cnt_clr,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, irq_take,
           pc_src, irq_vec, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use / redirect / interrupt sequencing for the 5-stage MIPS core, plus stall and flush perf counters.
// Latency: control outputs are combinational (0 cycles); IRQ state and counters update on clk rising edge.
// Backpressure: a load-use hazard holds PC and IF/ID for one cycle and bubbles ID/EX; redirects squash IF/ID.
// Ports: clk, reset (async, active-high), hz (hazard_ctrl_if.slave bundle of status in / controls out).
module hazard_ctrl #(
  parameter int          CNT_W   = 16,
  parameter logic [31:0] IRQ_VEC = 32'h8000_0004
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  localparam logic [2:0] PC_SEQ  = 3'd0;
  localparam logic [2:0] PC_BR   = 3'd1;
  localparam logic [2:0] PC_JMP  = 3'd2;
  localparam logic [2:0] PC_JREG = 3'd3;
  localparam logic [2:0] PC_IRQ  = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    TAKE = 2'd2,
    MASK = 2'd3
  } irq_state_t;

  irq_state_t       state;
  irq_state_t       state_nxt;
  logic             jump;
  logic             jreg;
  logic             uses_rt;
  logic             lu;
  logic             br_taken;
  logic             irq_win;
  logic             stall_inc;
  logic             flush_inc;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // ID-stage decode and hazard detection
  always_comb begin
    jump     = (hz.id_opcode == 6'h02) || (hz.id_opcode == 6'h03);
    jreg     = (hz.id_opcode == 6'h00) &&
               ((hz.id_funct == 6'h08) || (hz.id_funct == 6'h09));
    uses_rt  = (hz.id_opcode == 6'h00) || (hz.id_opcode == 6'h2b) ||
               (hz.id_opcode == 6'h04) || (hz.id_opcode == 6'h05);
    // The rs comparison is unconditional, so a JR/JALR whose target register
    // is the load destination is caught here as well.
    lu       = hz.ex_memread && (hz.ex_rt != 5'd0) &&
               ((hz.ex_rt == hz.id_rs) || (uses_rt && (hz.ex_rt == hz.id_rt)));
    br_taken = hz.ex_branch && hz.ex_branch_taken;
    // The trap only happens when nothing of higher priority wins this cycle
    // and the ID instruction is user-mode.
    irq_win  = (state == TAKE) && !br_taken && !lu && !hz.pc_kernel;
  end

  // Priority-encoded pipeline controls
  always_comb begin
    hz.pc_write    = 1'b1;
    hz.if_id_write = 1'b1;
    hz.if_id_flush = 1'b0;
    hz.id_ex_flush = 1'b0;
    hz.irq_take    = 1'b0;
    hz.pc_src      = PC_SEQ;
    if (reset) begin
      hz.pc_write    = 1'b0;
      hz.if_id_write = 1'b0;
      hz.if_id_flush = 1'b1;
      hz.id_ex_flush = 1'b1;
    end else if (br_taken) begin
      hz.pc_src      = PC_BR;
      hz.if_id_flush = 1'b1;
      hz.id_ex_flush = 1'b1;
    end else if (lu) begin
      hz.pc_write    = 1'b0;
      hz.if_id_write = 1'b0;
      hz.id_ex_flush = 1'b1;
    end else if (irq_win) begin
      hz.irq_take    = 1'b1;
      hz.pc_src      = PC_IRQ;
      hz.if_id_flush = 1'b1;
    end else if (jump) begin
      hz.pc_src      = PC_JMP;
      hz.if_id_flush = 1'b1;
    end else if (jreg) begin
      hz.pc_src      = PC_JREG;
      hz.if_id_flush = 1'b1;
    end
  end

  assign hz.irq_vec = IRQ_VEC;

  // Interrupt acceptance FSM
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (hz.irq_req && !hz.pc_kernel) state_nxt = PEND;
      PEND: begin
        if (!hz.irq_req)
          state_nxt = IDLE;
        else if (!(hz.ex_branch || lu || jump || jreg))
          state_nxt = TAKE;
      end
      // A TAKE cycle that lost to a higher-priority action did not trap,
      // so the request goes back to waiting instead of being masked.
      TAKE: state_nxt = irq_win ? MASK : PEND;
      MASK: if (!hz.pc_kernel && !hz.irq_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Saturating performance counters; clear beats increment
  assign stall_inc = lu && !br_taken;
  assign flush_inc = br_taken || (!lu && (irq_win || jump || jreg));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (hz.cnt_clr) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush_inc && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign hz.stall_cnt = stall_q;
  assign hz.flush_cnt = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver pushes model predictions, monitor pops and compares each cycle.
// Latency: predictions are checked on the falling edge of the cycle in which they were driven.
// Backpressure: none; the DUT answers every cycle.
module tb_hazard_ctrl;

  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct {
    bit       reset;
    bit       irq_req;
    bit       pc_kernel;
    bit [5:0] opcode;
    bit [5:0] funct;
    bit [4:0] rs;
    bit [4:0] rt;
    bit       ex_memread;
    bit [4:0] ex_rt;
    bit       ex_branch;
    bit       ex_taken;
    bit       cnt_clr;
  } stim_t;

  typedef struct {
    bit       pc_write;
    bit       if_id_write;
    bit       if_id_flush;
    bit       id_ex_flush;
    bit       irq_take;
    bit [2:0] pc_src;
    int       stall_cnt;
    int       flush_cnt;
  } exp_t;

  typedef enum {A_RST, A_BR, A_STALL, A_IRQ, A_J, A_JR, A_NONE} act_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  stim_t cur;

  // Reference model state: where the interrupt is in its life cycle
  bit m_waiting;   // request seen, waiting for a clean cycle
  bit m_ready;     // trap slot this cycle
  bit m_inhandler; // trapped, waiting for handler return and request drop
  int m_stall;
  int m_flush;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.CNT_W(CNT_W), .IRQ_VEC(32'h8000_0004)) dut (
    .clk  (clk),
    .reset(rst),
    .hz   (hz)
  );

  always #5 clk = ~clk;

  function automatic bit is_jump(stim_t s);
    return s.opcode inside {6'h02, 6'h03};
  endfunction

  function automatic bit is_jreg(stim_t s);
    return s.opcode == 6'h00 && s.funct inside {6'h08, 6'h09};
  endfunction

  function automatic bit hazard(stim_t s);
    bit reads_rt;
    reads_rt = s.opcode inside {6'h00, 6'h2b, 6'h04, 6'h05};
    return s.ex_memread && s.ex_rt != 0 &&
           (s.ex_rt == s.rs || (reads_rt && s.ex_rt == s.rt));
  endfunction

  function automatic act_t winner(stim_t s);
    if (s.reset)                       return A_RST;
    if (s.ex_branch && s.ex_taken)     return A_BR;
    if (hazard(s))                     return A_STALL;
    if (m_ready && !s.pc_kernel)       return A_IRQ;
    if (is_jump(s))                    return A_J;
    if (is_jreg(s))                    return A_JR;
    return A_NONE;
  endfunction

  function automatic exp_t model_out(stim_t s);
    exp_t e;
    e = '{pc_write: 1, if_id_write: 1, if_id_flush: 0, id_ex_flush: 0,
          irq_take: 0, pc_src: 0, stall_cnt: m_stall, flush_cnt: m_flush};
    case (winner(s))
      A_RST:   begin e.pc_write = 0; e.if_id_write = 0; e.if_id_flush = 1; e.id_ex_flush = 1; end
      A_BR:    begin e.pc_src = 1; e.if_id_flush = 1; e.id_ex_flush = 1; end
      A_STALL: begin e.pc_write = 0; e.if_id_write = 0; e.id_ex_flush = 1; end
      A_IRQ:   begin e.irq_take = 1; e.pc_src = 4; e.if_id_flush = 1; end
      A_J:     begin e.pc_src = 2; e.if_id_flush = 1; end
      A_JR:    begin e.pc_src = 3; e.if_id_flush = 1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic void model_reset();
    m_waiting = 0; m_ready = 0; m_inhandler = 0;
    m_stall = 0; m_flush = 0;
  endfunction

  // Clock-edge update using the inputs that were present during the cycle
  function automatic void model_advance(stim_t s);
    act_t a;
    bit   busy;
    if (s.reset) begin
      model_reset();
      return;
    end
    a = winner(s);
    if (s.cnt_clr) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if (a == A_STALL) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (a inside {A_BR, A_IRQ, A_J, A_JR}) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
    end
    busy = s.ex_branch || hazard(s) || is_jump(s) || is_jreg(s);
    if (m_ready) begin
      m_ready = 0;
      if (a == A_IRQ) m_inhandler = 1;
      else            m_waiting = 1;
    end else if (m_waiting) begin
      if (!s.irq_req)  m_waiting = 0;
      else if (!busy) begin m_waiting = 0; m_ready = 1; end
    end else if (m_inhandler) begin
      if (!s.pc_kernel && !s.irq_req) m_inhandler = 0;
    end else if (s.irq_req && !s.pc_kernel) begin
      m_waiting = 1;
    end
  endfunction

  task automatic apply(stim_t s);
    rst                = s.reset;
    hz.irq_req         = s.irq_req;
    hz.pc_kernel       = s.pc_kernel;
    hz.id_opcode       = s.opcode;
    hz.id_funct        = s.funct;
    hz.id_rs           = s.rs;
    hz.id_rt           = s.rt;
    hz.ex_memread      = s.ex_memread;
    hz.ex_rt           = s.ex_rt;
    hz.ex_branch       = s.ex_branch;
    hz.ex_branch_taken = s.ex_taken;
    hz.cnt_clr         = s.cnt_clr;
  endtask

  function automatic stim_t nop();
    stim_t s;
    s = '{reset: 0, irq_req: 0, pc_kernel: 0, opcode: 6'h08, funct: 6'h20,
          rs: 5'd1, rt: 5'd2, ex_memread: 0, ex_rt: 5'd0, ex_branch: 0,
          ex_taken: 0, cnt_clr: 0};
    return s;
  endfunction

  // One cycle: update model at the edge, then drive and predict
  task automatic step(stim_t s);
    @(posedge clk);
    model_advance(cur);
    #1;
    cur = s;
    if (s.reset) model_reset();
    apply(s);
    exp_q.push_back(model_out(s));
  endtask

  // Reset asserted and released between two clock edges
  task automatic reset_pulse();
    stim_t s;
    s = cur;
    @(posedge clk);
    model_advance(cur);
    #1;
    s.reset = 1;
    cur = s;
    model_reset();
    apply(s);
    exp_q.push_back(model_out(s));
    @(negedge clk);
    #1;
    s = nop();
    s.irq_req = 1;
    cur = s;
    apply(s);
  endtask

  task automatic cmp(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: compares whatever the DUT shows against the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("pc_write",    int'(hz.pc_write),    int'(e.pc_write));
        cmp("if_id_write", int'(hz.if_id_write), int'(e.if_id_write));
        cmp("if_id_flush", int'(hz.if_id_flush), int'(e.if_id_flush));
        cmp("id_ex_flush", int'(hz.id_ex_flush), int'(e.id_ex_flush));
        cmp("irq_take",    int'(hz.irq_take),    int'(e.irq_take));
        cmp("pc_src",      int'(hz.pc_src),      int'(e.pc_src));
        cmp("stall_cnt",   int'(hz.stall_cnt),   e.stall_cnt);
        cmp("flush_cnt",   int'(hz.flush_cnt),   e.flush_cnt);
      end
    end
  end

  initial begin
    stim_t s;
    bit    irq_level;
    logic [5:0] ops [8];
    logic [5:0] fns [4];
    ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h23, 6'h2b, 6'h08};
    fns = '{6'h08, 6'h09, 6'h20, 6'h22};
    irq_level = 0;

    model_reset();
    cur = nop();
    cur.reset = 1;
    apply(cur);

    // reset state held for a few cycles
    s = nop(); s.reset = 1;
    repeat (3) step(s);
    #1;
    cmp("irq_vec", int'(hz.irq_vec), int'(32'h8000_0004));

    // load-use: lw $8 in EX, add $9,$8,$10 in ID, then the load moves on
    s = nop(); s.opcode = 6'h00; s.funct = 6'h20; s.rs = 5'd8; s.rt = 5'd10;
    s.ex_memread = 1; s.ex_rt = 5'd8;
    step(s);
    s.ex_memread = 0;
    step(s);
    step(nop());

    // taken branch in EX overrides a J in ID
    s = nop(); s.opcode = 6'h02; s.ex_branch = 1; s.ex_taken = 1;
    step(s);
    step(nop());

    // JR depending on a load: one stall, then register redirect
    s = nop(); s.opcode = 6'h00; s.funct = 6'h08; s.rs = 5'd5; s.rt = 5'd0;
    s.ex_memread = 1; s.ex_rt = 5'd5;
    step(s);
    s.ex_memread = 0;
    step(s);
    step(nop());

    // IRQ path: trap, handler in kernel mode, return
    s = nop(); s.irq_req = 1;
    repeat (5) step(s);
    s.pc_kernel = 1;
    repeat (2) step(s);
    s.irq_req = 0;
    step(s);
    s.pc_kernel = 0;
    repeat (2) step(s);

    // IRQ deferred by branches in EX
    s = nop(); s.irq_req = 1; s.ex_branch = 1;
    repeat (3) step(s);
    s.ex_branch = 0;
    repeat (3) step(s);
    s.irq_req = 0; s.pc_kernel = 1;
    step(s);
    step(nop());

    // async reset while masked, released before the next edge
    s = nop(); s.irq_req = 1;
    repeat (5) step(s);
    reset_pulse();
    repeat (4) step(s);
    s.irq_req = 0; s.pc_kernel = 1;
    step(s);
    step(nop());

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s = nop();
      if ($urandom_range(0, 14) == 0) irq_level = ~irq_level;
      s.irq_req    = irq_level;
      s.pc_kernel  = ($urandom_range(0, 5) == 0);
      s.opcode     = ops[$urandom_range(0, 7)];
      s.funct      = fns[$urandom_range(0, 3)];
      s.rs         = 5'($urandom_range(0, 3));
      s.rt         = 5'($urandom_range(0, 3));
      s.ex_rt      = 5'($urandom_range(0, 3));
      s.ex_memread = ($urandom_range(0, 2) == 0);
      s.ex_branch  = ($urandom_range(0, 3) == 0);
      s.ex_taken   = 1'($urandom_range(0, 1));
      s.cnt_clr    = ($urandom_range(0, 40) == 0);
      s.reset      = ($urandom_range(0, 150) == 0);
      step(s);
    end

    // saturation: clear, then more stalls than the counter can hold
    s = nop(); s.cnt_clr = 1;
    step(s);
    s = nop(); s.opcode = 6'h00; s.rs = 5'd8; s.ex_memread = 1; s.ex_rt = 5'd8;
    repeat (CMAX + 2) step(s);
    repeat (2) step(s);
    s.cnt_clr = 1;
    step(s);
    s.cnt_clr = 0;
    repeat (2) step(s);
    step(nop());

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
